clk_div_multi: RTL and testbench

Multi-channel programmable clock divider, successor to the single fixed-ratio divider. Each of CH channels produces a 50 % duty divided clock and an optional one-cycle rising-edge tick. Each channel has a runtime-writable half-period register. Ratio changes are shadowed and applied only at a period boundary, so no output period is ever truncated. Sits beside the CPU core and feeds slow-peripheral clocks and enables (display scan, UART baud, debounce) from the single system clock.

---
 rtl/clk_div_pkg.sv | 16 +
 rtl/clk_div_multi_if.sv | 22 ++
 rtl/clk_div_multi_ch.sv | 91 +++++++++
 rtl/clk_div_multi.sv | 50 +++++
 tb/tb_clk_div_multi.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: constants and helpers shared by the clk_div_multi block.
//   ch_idx_w(ch) : width of a channel index, max(1, clog2(ch))
//   CW_DEF       : default half-period counter width
//   DIV_INIT_DEF : default reset half-period
//   DIV_STOP     : divisor encoding that holds a channel stopped
package clk_div_pkg;

  localparam int CW_DEF       = 16;
  localparam int DIV_INIT_DEF = 8;
  localparam int DIV_STOP     = 0;

  function automatic int ch_idx_w(input int ch);
    return (ch < 2) ? 1 : $clog2(ch);
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if: divisor configuration bus of clk_div_multi.
//   cfg_we  : write strobe, one write per asserted cycle
//   cfg_ch  : target channel index (ch_idx_w(CH) bits)
//   cfg_div : new half-period in clk cycles, 0 stops the channel
// master drives the bus (CPU side), slave is the divider.
interface clk_div_multi_if
  import clk_div_pkg::*;
#(
  parameter int CH = 4,
  parameter int CW = CW_DEF
);

  localparam int CHW = ch_idx_w(CH);

  logic           cfg_we;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_div;

  modport master (output cfg_we, output cfg_ch, output cfg_div);
  modport slave  (input  cfg_we, input  cfg_ch, input  cfg_div);

endinterface

// File: rtl/clk_div_multi_ch.sv
// clk_div_ch: one channel of the multi-channel divider.
// Holds the half-period counter, the active and shadow divisors and the
// registered divided clock / tick outputs.
//   clk, reset_n : system clock, asynchronous active-low reset
//   en           : channel run enable (level)
//   wr_en        : write strobe for this channel (already decoded)
//   wr_div       : new half-period, 0 = stop
//   clk_div      : 50 % duty divided clock, registered
//   tick         : one-cycle pulse on each clk_div rise, registered
//   busy         : a shadow divisor is waiting to become active
// Optional feature macro: CLK_DIV_TICK_EN (tick built when defined,
// otherwise tick is tied low and its flop is not built).
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CW       = CW_DEF,
  parameter int DIV_INIT = DIV_INIT_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_div,
  output logic          clk_div,
  output logic          tick,
  output logic          busy
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] div_a;
  logic [CW-1:0] div_s;
  logic          pend;
  logic          running;
  logic          at_end;

  assign running = en && (div_a != CW'(DIV_STOP));
  // Only meaningful while running, so div_a-1 never wraps in use.
  assign at_end  = (cnt == (div_a - CW'(1)));
  assign busy    = pend;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      div_a   <= CW'(DIV_INIT);
      div_s   <= CW'(DIV_INIT);
      pend    <= 1'b0;
      clk_div <= 1'b0;
    end else begin
      if (running) begin
        if (at_end) begin
          cnt     <= '0;
          clk_div <= ~clk_div;
          // Swap ratios only on the falling toggle so the new ratio starts
          // with a full low phase and no period is ever cut short.
          if (clk_div && pend) begin
            div_a <= div_s;
            pend  <= 1'b0;
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt     <= '0;
        clk_div <= 1'b0;
        if (pend) begin
          div_a <= div_s;
          pend  <= 1'b0;
        end
      end
      // A write on the same edge as an apply re-arms pend with the newer
      // value, so back-to-back writes leave the last one pending.
      if (wr_en) begin
        div_s <= wr_div;
        pend  <= 1'b1;
      end
    end
  end

`ifdef CLK_DIV_TICK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick <= 1'b0;
    end else begin
      tick <= running && at_end && !clk_div;
    end
  end
`else
  assign tick = 1'b0;
`endif

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: CH-channel programmable clock divider.
// Each channel outputs a 50 % duty clock of period 2*div and a rise tick;
// divisor writes are shadowed and take effect at a period boundary.
//   clk, reset_n : system clock, asynchronous active-low reset
//   en[CH]       : per-channel run enable
//   cfg          : clk_div_multi_if.slave (cfg_we, cfg_ch, cfg_div)
//   clk_div[CH]  : divided clocks
//   tick[CH]     : one-cycle pulse on each clk_div rise
//   busy[CH]     : shadow divisor pending
// Optional feature macro: CLK_DIV_TICK_EN (see clk_div_ch).
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int CH       = 4,
  parameter int CW       = CW_DEF,
  parameter int DIV_INIT = DIV_INIT_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [CH-1:0]        en,
  clk_div_multi_if.slave       cfg,
  output logic [CH-1:0]        clk_div,
  output logic [CH-1:0]        tick,
  output logic [CH-1:0]        busy
);

  localparam int CHW = ch_idx_w(CH);

  // One-hot write enable; indices >= CH match no channel and are dropped.
  logic [CH-1:0] wr_oh;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    assign wr_oh[g] = cfg.cfg_we && (cfg.cfg_ch == CHW'(g));

    clk_div_ch #(
      .CW       (CW),
      .DIV_INIT (DIV_INIT)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en[g]),
      .wr_en   (wr_oh[g]),
      .wr_div  (cfg.cfg_div),
      .clk_div (clk_div[g]),
      .tick    (tick[g]),
      .busy    (busy[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;

`ifdef CLK_DIV_TICK_EN
  localparam bit TICK_ON = 1'b1;
`else
  localparam bit TICK_ON = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic [3:0] en;
  logic [3:0] clk_div, tick, busy;
  logic [2:0] en3;
  logic [2:0] clk_div3, tick3, busy3;

  int total;
  int bad;

  clk_div_multi_if #(.CH(4), .CW(16)) cfg_bus ();
  clk_div_multi_if #(.CH(3), .CW(16)) cfg_bus3 ();

  clk_div_multi #(.CH(4), .CW(16), .DIV_INIT(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .cfg     (cfg_bus),
    .clk_div (clk_div),
    .tick    (tick),
    .busy    (busy)
  );

  clk_div_multi #(.CH(3), .CW(16), .DIV_INIT(8)) dut3 (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en3),
    .cfg     (cfg_bus3),
    .clk_div (clk_div3),
    .tick    (tick3),
    .busy    (busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  en;
    logic        we;
    logic [1:0]  ch;
    logic [15:0] div;
    logic [3:0]  exp_clk;
    logic [3:0]  exp_tick;
    logic [3:0]  exp_busy;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit ph16(input int k);
    return ((k / 8) % 2) == 1;
  endfunction

  initial begin
    logic [3:0] ec, et, eb;
    total = 0;
    bad   = 0;

    // Reset state
    reset_n = 1'b0;
    en = 4'h0;
    en3 = 3'h0;
    cfg_bus.cfg_we = 1'b0;  cfg_bus.cfg_ch = '0;  cfg_bus.cfg_div = '0;
    cfg_bus3.cfg_we = 1'b0; cfg_bus3.cfg_ch = '0; cfg_bus3.cfg_div = '0;
    step();
    step();
    chk("rst clk_div", 32'(clk_div), 32'h0);
    chk("rst tick", 32'(tick), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst clk_div3", 32'(clk_div3), 32'h0);
    chk("rst busy3", 32'(busy3), 32'h0);
    reset_n = 1'b1;
    en = 4'hF;

    // Default period 16, ch1 -> div 3 mid-high, ch2 -> div 0 mid-high
    for (int k = 1; k <= 60; k++) begin
      step();
      ec = '0; et = '0; eb = '0;
      ec[0] = ph16(k);
      et[0] = (k % 16) == 8;
      ec[3] = ph16(k);
      et[3] = (k % 16) == 8;
      ec[1] = (k < 16) ? ph16(k) : ((((k - 16) / 3) % 2) == 1);
      et[1] = (k < 16) ? (k == 8) : (((k - 16) % 6) == 3);
      eb[1] = (k >= 11) && (k <= 15);
      ec[2] = (k < 48) ? ph16(k) : 1'b0;
      et[2] = (k < 48) && ((k % 16) == 8);
      eb[2] = (k >= 41) && (k <= 47);
      chk($sformatf("run clk_div k=%0d", k), 32'(clk_div), 32'(ec));
      chk($sformatf("run tick k=%0d", k), 32'(tick), 32'(et & {4{TICK_ON}}));
      chk($sformatf("run busy k=%0d", k), 32'(busy), 32'(eb));
      cfg_bus.cfg_we  = (k == 10) || (k == 40);
      cfg_bus.cfg_ch  = (k == 10) ? 2'd1 : 2'd2;
      cfg_bus.cfg_div = (k == 10) ? 16'd3 : 16'd0;
    end

    // Pending write then async reset between edges
    cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_ch = 2'd0; cfg_bus.cfg_div = 16'd5;
    step();
    cfg_bus.cfg_we = 1'b0;
    chk("pre-reset clk_div", 32'(clk_div), 32'hB);
    chk("pre-reset busy", 32'(busy), 32'h1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async rst clk_div", 32'(clk_div), 32'h0);
    chk("async rst tick", 32'(tick), 32'h0);
    chk("async rst busy", 32'(busy), 32'h0);
    step();
    reset_n = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      step();
      chk($sformatf("post-rst clk_div j=%0d", j), 32'(clk_div), (j >= 8) ? 32'hF : 32'h0);
      chk($sformatf("post-rst tick j=%0d", j), 32'(tick), (j == 8 && TICK_ON) ? 32'hF : 32'h0);
      chk($sformatf("post-rst busy j=%0d", j), 32'(busy), 32'h0);
    end

    // Table-driven vectors from a fresh reset with all channels stopped
    en = 4'h0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    tbl[0]  = '{4'h0, 1'b1, 2'd0, 16'd1, 4'h0, 4'h0, 4'h1};
    tbl[1]  = '{4'h0, 1'b1, 2'd1, 16'd2, 4'h0, 4'h0, 4'h2};
    tbl[2]  = '{4'h0, 1'b1, 2'd2, 16'd3, 4'h0, 4'h0, 4'h4};
    tbl[3]  = '{4'h0, 1'b1, 2'd3, 16'd0, 4'h0, 4'h0, 4'h8};
    tbl[4]  = '{4'h0, 1'b0, 2'd0, 16'd0, 4'h0, 4'h0, 4'h0};
    tbl[5]  = '{4'hF, 1'b0, 2'd0, 16'd0, 4'h1, 4'h1, 4'h0};
    tbl[6]  = '{4'hF, 1'b0, 2'd0, 16'd0, 4'h2, 4'h2, 4'h0};
    tbl[7]  = '{4'hF, 1'b0, 2'd0, 16'd0, 4'h7, 4'h5, 4'h0};
    tbl[8]  = '{4'hF, 1'b0, 2'd0, 16'd0, 4'h4, 4'h0, 4'h0};
    tbl[9]  = '{4'hF, 1'b0, 2'd0, 16'd0, 4'h5, 4'h1, 4'h0};
    tbl[10] = '{4'hF, 1'b1, 2'd3, 16'd1, 4'h2, 4'h2, 4'h8};
    tbl[11] = '{4'hF, 1'b0, 2'd0, 16'd0, 4'h3, 4'h1, 4'h0};
    tbl[12] = '{4'hF, 1'b0, 2'd0, 16'd0, 4'h8, 4'h8, 4'h0};
    tbl[13] = '{4'hF, 1'b0, 2'd0, 16'd0, 4'h5, 4'h5, 4'h0};
    tbl[14] = '{4'hB, 1'b0, 2'd0, 16'd0, 4'hA, 4'hA, 4'h0};
    tbl[15] = '{4'hF, 1'b0, 2'd0, 16'd0, 4'h3, 4'h1, 4'h0};
    tbl[16] = '{4'hF, 1'b0, 2'd0, 16'd0, 4'h8, 4'h8, 4'h0};
    tbl[17] = '{4'hF, 1'b0, 2'd0, 16'd0, 4'h5, 4'h5, 4'h0};
    for (int i = 0; i < 18; i++) begin
      en              = tbl[i].en;
      cfg_bus.cfg_we  = tbl[i].we;
      cfg_bus.cfg_ch  = tbl[i].ch;
      cfg_bus.cfg_div = tbl[i].div;
      step();
      chk($sformatf("tbl clk_div r%0d", i), 32'(clk_div), 32'(tbl[i].exp_clk));
      chk($sformatf("tbl tick r%0d", i), 32'(tick), 32'(tbl[i].exp_tick & {4{TICK_ON}}));
      chk($sformatf("tbl busy r%0d", i), 32'(busy), 32'(tbl[i].exp_busy));
    end
    cfg_bus.cfg_we = 1'b0;

    // CH=3: out-of-range index ignored, back-to-back writes keep the last
    cfg_bus3.cfg_we = 1'b1; cfg_bus3.cfg_ch = 2'd3; cfg_bus3.cfg_div = 16'd2;
    step();
    chk("ch3 bad idx busy", 32'(busy3), 32'h0);
    cfg_bus3.cfg_we = 1'b0;
    step();
    chk("ch3 bad idx busy+1", 32'(busy3), 32'h0);
    cfg_bus3.cfg_we = 1'b1; cfg_bus3.cfg_ch = 2'd0; cfg_bus3.cfg_div = 16'd5;
    step();
    chk("ch3 wr5 busy", 32'(busy3), 32'h1);
    cfg_bus3.cfg_div = 16'd7;
    step();
    chk("ch3 wr7 busy", 32'(busy3), 32'h1);
    cfg_bus3.cfg_we = 1'b0;
    step();
    chk("ch3 applied busy", 32'(busy3), 32'h0);
    en3 = 3'h7;
    for (int j = 1; j <= 16; j++) begin
      step();
      ec = '0; et = '0;
      ec[0] = (j >= 7) && (j < 14);
      et[0] = (j == 7);
      ec[1] = (j >= 8) && (j < 16);
      ec[2] = ec[1];
      et[1] = (j == 8);
      et[2] = et[1];
      chk($sformatf("ch3 clk_div j=%0d", j), 32'(clk_div3), 32'(ec[2:0]));
      chk($sformatf("ch3 tick j=%0d", j), 32'(tick3), 32'(et[2:0] & {3{TICK_ON}}));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
